// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_seq_pkg                                                  |
// | Purpose  : Shared definitions for the iterative multiply/divide unit:      |
// |            op-field bit positions and values, and the FSM state encoding.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package muldiv_seq_pkg;

    // op[0] selects MUL/DIV, op[1] requests two's-complement operands
    localparam int   OP_DIV_BIT    = 0;
    localparam int   OP_SIGNED_BIT = 1;
    localparam logic OP_MUL        = 1'b0;
    localparam logic OP_DIV        = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_step                                                     |
// | Purpose  : One combinational iteration of the multiply/divide accumulator. |
// |            MUL: right-shift add on {carry, acc_hi, acc_lo}.                |
// |            DIV: restoring left-shift step, remainder in acc_hi, quotient   |
// |            bits shifted into acc_lo.                                       |
// | Ports    : i_is_div   - 1 selects the divide step                          |
// |            i_acc_hi   - accumulator high half / partial remainder          |
// |            i_acc_lo   - accumulator low half / dividend-quotient shifter   |
// |            i_operand  - multiplicand or divisor                            |
// |            o_acc_hi   - next high half                                     |
// |            o_acc_lo   - next low half                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_rem;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_rem_next;
    logic           w_no_borrow;
    logic           w_unused_rem_msb;

    always_comb begin
        // Carry of the add lands in w_sum[WIDTH] and is shifted straight back
        // into the top of acc_hi, so no separate carry flop is needed.
        w_sum       = {1'b0, i_acc_hi} + (i_acc_lo[0] ? {1'b0, i_operand} : '0);

        w_rem       = {i_acc_hi, i_acc_lo[WIDTH-1]};
        w_no_borrow = (w_rem >= {1'b0, i_operand});
        w_trial     = w_rem - {1'b0, i_operand};
        w_rem_next  = w_no_borrow ? w_trial : w_rem;

        if (i_is_div == OP_DIV) begin
            o_acc_hi = w_rem_next[WIDTH-1:0];
            o_acc_lo = {i_acc_lo[WIDTH-2:0], w_no_borrow};
        end else begin
            o_acc_hi = w_sum[WIDTH:1];
            o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
        end
    end

    // The restored remainder is always below the divisor, so its top bit is 0.
    assign w_unused_rem_msb = w_rem_next[WIDTH];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_seq                                                      |
// | Purpose  : Iterative WIDTH-bit multiply / restoring divide with a          |
// |            start/done handshake and a one-cycle divide-by-zero fast path.  |
// | Macro    : MULDIV_SIGNED_EN - when defined, op[1]=1 selects signed         |
// |            operands and a FIX state applies the sign correction.           |
// | Ports    : clk, reset      - clock, synchronous active-high reset          |
// |            start, op, a, b - launch request, operation, operands           |
// |            ready, busy     - handshake status                              |
// |            done            - one-cycle result pulse                        |
// |            lo, hi          - product halves / quotient, remainder          |
// |            ovf, div_zero   - overflow and divide-by-zero flags             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic             r_ovf;
    logic             r_div_zero;

    logic             w_accept;
    logic             w_op_div;
    logic             w_b_zero_div;
    logic             w_last;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;
    logic             w_res_ovf;

    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy     = (r_state == S_RUN)  || (r_state == S_FIX);
    assign done     = (r_state == S_DONE);
    assign lo       = r_lo;
    assign hi       = r_hi;
    assign ovf      = r_ovf;
    assign div_zero = r_div_zero;

    assign w_accept     = start && ready;
    assign w_op_div     = (op[OP_DIV_BIT] != OP_MUL);
    assign w_b_zero_div = w_op_div && (b == '0);
    assign w_last       = (r_cnt == CNT_W'(1));

`ifdef MULDIV_SIGNED_EN
    logic                 r_signed;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div_ovf;
    logic                 w_sa;
    logic                 w_sb;
    logic [2*WIDTH-1:0]   w_prod_neg;
    logic [WIDTH-1:0]     w_ext;

    assign w_sa    = op[OP_SIGNED_BIT] & a[WIDTH-1];
    assign w_sb    = op[OP_SIGNED_BIT] & b[WIDTH-1];
    assign w_mag_a = w_sa ? -a : a;
    assign w_mag_b = w_sb ? -b : b;

    // Sign correction applied in FIX. MIN/-1 needs no special case here:
    // |MIN| / 1 = MIN, and negating MIN yields MIN again with remainder 0.
    always_comb begin
        w_prod_neg = -{r_hi, r_lo};
        w_res_hi   = r_hi;
        w_res_lo   = r_lo;
        if (r_is_div) begin
            if (r_neg_q) w_res_lo = -r_lo;
            if (r_neg_r) w_res_hi = -r_hi;
        end else if (r_neg_q) begin
            w_res_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_neg[WIDTH-1:0];
        end
        w_ext     = r_signed ? {WIDTH{w_res_lo[WIDTH-1]}} : '0;
        w_res_ovf = r_is_div ? r_div_ovf : (w_res_hi != w_ext);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div_ovf <= 1'b0;
        end else if (w_accept) begin
            r_signed  <= op[OP_SIGNED_BIT];
            r_neg_q   <= w_sa ^ w_sb;
            r_neg_r   <= w_sa;
            r_div_ovf <= w_op_div && op[OP_SIGNED_BIT] &&
                         (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        end
    end
`else
    logic w_unused_op;

    assign w_unused_op = op[OP_SIGNED_BIT];
    assign w_mag_a     = a;
    assign w_mag_b     = b;
    assign w_res_hi    = w_step_hi;
    assign w_res_lo    = w_step_lo;
    assign w_res_ovf   = !r_is_div && (w_step_hi != '0);
`endif

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_is_div  (r_is_div),
        .i_acc_hi  (r_hi),
        .i_acc_lo  (r_lo),
        .i_operand (r_opnd),
        .o_acc_hi  (w_step_hi),
        .o_acc_lo  (w_step_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)              w_next_state = w_b_zero_div ? S_DONE : S_RUN;
                else                    w_next_state = S_IDLE;
            end
            S_RUN: begin
`ifdef MULDIV_SIGNED_EN
                if (w_last)             w_next_state = S_FIX;
`else
                if (w_last)             w_next_state = S_DONE;
`endif
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX:                      w_next_state = S_DONE;
`endif
            default:                    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_ovf      <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_is_div   <= w_op_div;
            r_ovf      <= 1'b0;
            r_div_zero <= w_b_zero_div;
            if (w_b_zero_div) begin
                r_cnt  <= '0;
                r_lo   <= '1;
                r_hi   <= a;
                r_opnd <= '0;
            end else begin
                // DIV shifts the dividend out of lo; MUL inspects the
                // multiplier bits in lo and adds the multiplicand.
                r_cnt  <= CNT_W'(WIDTH);
                r_hi   <= '0;
                r_lo   <= w_op_div ? w_mag_a : w_mag_b;
                r_opnd <= w_op_div ? w_mag_b : w_mag_a;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_hi  <= w_step_hi;
            r_lo  <= w_step_lo;
`ifndef MULDIV_SIGNED_EN
            if (w_last) r_ovf <= w_res_ovf;
`endif
        end
`ifdef MULDIV_SIGNED_EN
        else if (r_state == S_FIX) begin
            r_hi  <= w_res_hi;
            r_lo  <= w_res_lo;
            r_ovf <= w_res_ovf;
        end
`endif
    end

endmodule
`default_nettype wire
